bytewrite_ram_ctrl: RTL and testbench

Request-side controller for the 32-bit byte-write single-port RAM (4 byte lanes, write-first read port, 1-cycle read latency). Accepts byte/halfword/word load and store requests on a valid/ready interface, drives the RAM's enable, per-lane write enables, word address and lane-replicated write data, then returns lane-extracted, zero-extended responses in order. Credit-based flow control and a response FIFO let the RAM run at one access per cycle under response backpressure.

---
 rtl/bytewrite_ram_pkg.sv | 48 ++++
 rtl/bytewrite_rsp_fifo.sv | 110 +++++++++++
 rtl/bytewrite_ram_ctrl.sv | 169 ++++++++++++++++
 tb/tb_bytewrite_ram_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bytewrite_ram_pkg.sv
// Shared definitions for the byte-write RAM request controller.
//
// Contents:
//   size_e          request size encodings (byte, halfword, word, illegal)
//   rsp_entry_t     response FIFO entry {err, rdata[31:0]}
//   lane_mask()     byte-lane mask of an aligned access of a given size/offset
//   is_misaligned() true for an illegal size or an offset not aligned to size
package bytewrite_ram_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'd0,
    SZ_HALF    = 2'd1,
    SZ_WORD    = 2'd2,
    SZ_ILLEGAL = 2'd3
  } size_e;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } rsp_entry_t;

  // Only meaningful for aligned accesses; a halfword is assumed to sit on
  // lanes 0-1 or 2-3 depending on offset bit 1.
  function automatic logic [3:0] lane_mask(size_e size, logic [1:0] offset);
    logic [3:0] mask;
    mask = 4'b0000;
    case (size)
      SZ_BYTE: mask = 4'b0001 << offset;
      SZ_HALF: mask = offset[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

  function automatic logic is_misaligned(size_e size, logic [1:0] offset);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = offset[0];
      SZ_WORD: bad = (offset != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/bytewrite_rsp_fifo.sv
// Synchronous FIFO with a registered head.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   push, push_data   write an entry (must not be asserted while full)
//   pop               consume the head entry (ignored while empty)
//   full, empty       occupancy flags (empty is the inverse of head valid)
//   pop_data          head entry, driven straight from a register
//
// The head lives in its own register so pop_data never goes through the
// storage read mux. An entry pushed into an empty FIFO lands directly in
// the head register and is visible the following cycle.
module bytewrite_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] pop_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             head_valid_q, head_valid_d;
  logic [WIDTH-1:0] head_data_q, head_data_d;

  logic             pop_eff;
  logic             head_free;
  logic [CW-1:0]    backlog;
  logic             bypass;

  always_comb begin
    full     = (count_q == CW'(DEPTH));
    empty    = ~head_valid_q;
    pop_data = head_data_q;

    pop_eff   = pop & head_valid_q;
    head_free = ~head_valid_q | pop_eff;
    // Entries waiting in storage behind the head register.
    backlog   = count_q - CW'(head_valid_q);
    bypass    = push & head_free & (backlog == '0);

    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    head_valid_d = head_valid_q;
    head_data_d  = head_data_q;

    if (head_free) begin
      if (backlog != '0) begin
        head_data_d  = mem_q[rd_ptr_q];
        head_valid_d = 1'b1;
        rd_ptr_d     = rd_ptr_q + PW'(1);
      end else if (push) begin
        head_data_d  = push_data;
        head_valid_d = 1'b1;
      end else begin
        head_data_d  = '0;
        head_valid_d = 1'b0;
      end
    end

    if (push && !bypass) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end

    count_d = count_q + CW'(push) - CW'(pop_eff);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      head_valid_q <= 1'b0;
      head_data_q  <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      head_valid_q <= head_valid_d;
      head_data_q  <= head_data_d;
    end
  end

  // Storage needs no reset: pointers and count decide what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // The credit scheme upstream guarantees a push never meets a full FIFO.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(push && full));
    end
  end

endmodule

// File: rtl/bytewrite_ram_ctrl.sv
// Request-side controller for a 32-bit, 4-lane byte-write single-port RAM.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   req_valid/req_ready             request handshake
//   req_we, req_size, req_addr,
//   req_wdata                       store flag, size (0 B,1 H,2 W,3 bad),
//                                   byte address, right-aligned store data
//   rsp_valid/rsp_ready             response handshake
//   rsp_rdata, rsp_err              zero-extended load data, error flag
//   ram_ena, ram_we, ram_addr,
//   ram_din, ram_dout               RAM port (1-cycle read latency)
//
// Pipeline: RAM access in the accept cycle, lane extraction in the
// in-flight stage one cycle later, response FIFO head the cycle after.
// A credit counter bounds accepted-but-unpopped requests to the FIFO depth,
// so the FIFO never overflows and the RAM can run every cycle.
module bytewrite_ram_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  ram_ena,
  output logic [3:0]            ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_din,
  input  logic [31:0]           ram_dout
);

  import bytewrite_ram_pkg::*;

  localparam int            CW         = $clog2(RSP_DEPTH + 1);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(RSP_DEPTH);

  logic [CW-1:0] credit_q, credit_d;
  logic          fl_valid_q, fl_valid_d;
  logic          fl_we_q, fl_we_d;
  size_e         fl_size_q, fl_size_d;
  logic [1:0]    fl_off_q, fl_off_d;
  logic          fl_err_q, fl_err_d;

  size_e         req_sz;
  logic [1:0]    req_off;
  logic          req_err;
  logic          accept;
  logic          pop;
  logic [31:0]   shifted;
  rsp_entry_t    push_entry;
  rsp_entry_t    head_entry;
  logic          fifo_full;
  logic          fifo_empty;

  // Request decode and RAM drive. req_ready is held low during reset so
  // nothing is accepted (and the RAM is never enabled) while rst_n is low.
  always_comb begin
    req_sz    = size_e'(req_size);
    req_off   = req_addr[1:0];
    req_err   = is_misaligned(req_sz, req_off);
    req_ready = rst_n & (credit_q < CREDIT_MAX);
    accept    = req_valid & req_ready;
    ram_ena   = accept & ~req_err;
    ram_addr  = req_addr[ADDR_WIDTH+1:2];
    ram_we    = ram_ena ? (lane_mask(req_sz, req_off) & {4{req_we}}) : 4'b0000;
    case (req_sz)
      SZ_BYTE: ram_din = {4{req_wdata[7:0]}};
      SZ_HALF: ram_din = {2{req_wdata[15:0]}};
      default: ram_din = req_wdata;
    endcase
  end

  // In-flight stage: every accepted request, errored or not, takes a slot
  // so responses leave in acceptance order.
  always_comb begin
    fl_valid_d = accept;
    fl_we_d    = fl_we_q;
    fl_size_d  = fl_size_q;
    fl_off_d   = fl_off_q;
    fl_err_d   = fl_err_q;
    if (accept) begin
      fl_we_d   = req_we;
      fl_size_d = req_sz;
      fl_off_d  = req_off;
      fl_err_d  = req_err;
    end
  end

  // Lane extraction from the RAM read data, zero-extended to 32 bits.
  always_comb begin
    shifted          = ram_dout >> {fl_off_q, 3'b000};
    push_entry.err   = fl_err_q;
    push_entry.rdata = 32'h0;
    if (!fl_we_q && !fl_err_q) begin
      case (fl_size_q)
        SZ_BYTE: push_entry.rdata = {24'h0, shifted[7:0]};
        SZ_HALF: push_entry.rdata = {16'h0, shifted[15:0]};
        SZ_WORD: push_entry.rdata = shifted;
        default: push_entry.rdata = 32'h0;
      endcase
    end
  end

  // Credits count requests accepted but not yet popped, including those
  // still in the in-flight stage.
  always_comb begin
    pop      = rsp_valid & rsp_ready;
    credit_d = credit_q;
    case ({accept, pop})
      2'b10:   credit_d = credit_q + CW'(1);
      2'b01:   credit_d = credit_q - CW'(1);
      default: credit_d = credit_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      credit_q   <= '0;
      fl_valid_q <= 1'b0;
      fl_we_q    <= 1'b0;
      fl_size_q  <= SZ_BYTE;
      fl_off_q   <= 2'b00;
      fl_err_q   <= 1'b0;
    end else begin
      credit_q   <= credit_d;
      fl_valid_q <= fl_valid_d;
      fl_we_q    <= fl_we_d;
      fl_size_q  <= fl_size_d;
      fl_off_q   <= fl_off_d;
      fl_err_q   <= fl_err_d;
    end
  end

  bytewrite_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH ($bits(rsp_entry_t))
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fl_valid_q),
    .push_data (push_entry),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .pop_data  (head_entry)
  );

  always_comb begin
    rsp_valid = ~fifo_empty;
    rsp_rdata = head_entry.rdata;
    rsp_err   = head_entry.err;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(fl_valid_q && fifo_full && !pop));
    end
  end

endmodule

// File: tb/tb_bytewrite_ram_ctrl.sv
module tb_bytewrite_ram_ctrl;

  localparam int AW    = 10;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [11:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        ram_ena;
  logic [3:0]  ram_we;
  logic [9:0]  ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout = '0;

  always #5 clk = ~clk;

  bytewrite_ram_ctrl #(.ADDR_WIDTH(AW), .RSP_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_ena(ram_ena), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // Behavioural write-first RAM with one cycle of read latency.
  logic [31:0] ram_mem [0:1023];

  function automatic logic [31:0] mergeWrite(input logic [31:0] old_w, input logic [31:0] din,
                                             input logic [3:0] we);
    logic [31:0] w;
    w = old_w;
    for (int i = 0; i < 4; i++) if (we[i]) w[8*i +: 8] = din[8*i +: 8];
    return w;
  endfunction

  always @(posedge clk) begin
    if (ram_ena) begin
      ram_mem[ram_addr] <= mergeWrite(ram_mem[ram_addr], ram_din, ram_we);
      ram_dout          <= mergeWrite(ram_mem[ram_addr], ram_din, ram_we);
    end
  end

  // Reference model: byte-addressed memory image plus an ordered queue of
  // expected responses tagged with the earliest cycle each may appear.
  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          rdy;
  } exp_t;

  logic [7:0]  gold [0:4095];
  exp_t        q[$];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          accepts_total = 0;
  int          pops_total = 0;
  logic        last_acc;
  logic        last_pop;
  logic        last_err;
  logic [31:0] last_rdata;
  logic [3:0]  last_ram_we;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, compare everything against the model,
  // then advance the model by whatever handshakes happened.
  task automatic applyStimulus(input logic v, input logic we, input logic [1:0] size,
                               input logic [11:0] addr, input logic [31:0] wd, input logic rr);
    logic        err_m, exp_ready, exp_ena, exp_valid;
    int          n;
    logic [3:0]  m;
    logic [31:0] din_e, rd;
    exp_t        e;
    @(negedge clk);
    req_valid = v; req_we = we; req_size = size; req_addr = addr; req_wdata = wd; rsp_ready = rr;
    #1;
    err_m = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
    n = 1 << size;
    exp_ready = (q.size() < DEPTH);
    checkOutput("req_ready", req_ready, exp_ready);
    exp_ena = v && exp_ready && !err_m;
    checkOutput("ram_ena", ram_ena, exp_ena);
    m = 4'b0000;
    if (exp_ena && we) for (int k = 0; k < n; k++) m[int'(addr[1:0]) + k] = 1'b1;
    checkOutput("ram_we", ram_we, m);
    last_ram_we = ram_we;
    if (exp_ena) checkOutput("ram_addr", ram_addr, addr[11:2]);
    if (exp_ena && we) begin
      case (size)
        2'd0:    din_e = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
        2'd1:    din_e = {wd[15:0], wd[15:0]};
        default: din_e = wd;
      endcase
      checkOutput("ram_din", ram_din, din_e);
    end
    exp_valid = (q.size() > 0) && (cyc >= q[0].rdy);
    checkOutput("rsp_valid", rsp_valid, exp_valid);
    last_pop = 1'b0;
    if (rsp_valid && rr) begin
      if (q.size() == 0) checkOutput("rsp_unexpected", 1, 0);
      else begin
        checkOutput("rsp_rdata", rsp_rdata, q[0].rdata);
        checkOutput("rsp_err", rsp_err, q[0].err);
        q.delete(0);
      end
      last_pop = 1'b1; last_rdata = rsp_rdata; last_err = rsp_err;
      pops_total++;
    end
    last_acc = v && req_ready;
    if (last_acc) begin
      rd = 32'h0;
      if (!err_m) begin
        for (int k = 0; k < n; k++) begin
          if (we) gold[(int'(addr) + k) & 4095] = wd[8*k +: 8];
          else    rd = rd | (32'(gold[(int'(addr) + k) & 4095]) << (8*k));
        end
      end
      e.err = err_m; e.rdata = rd; e.rdy = cyc + 2;
      q.push_back(e);
      accepts_total++;
    end
    cyc++;
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_req_ready", req_ready, 1);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 0);
    checkOutput("rst_rsp_err", rsp_err, 0);
    checkOutput("rst_ram_ena", ram_ena, 0);
    checkOutput("rst_ram_we", ram_we, 0);
    q.delete();
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  exp_we;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[17];

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int a0, p0, b;
    for (int i = 0; i < 4096; i++) gold[i] = 8'h00;
    for (int i = 0; i < 1024; i++) ram_mem[i] = 32'h0;

    vecs[0]  = '{1'b1, 2'd2, 12'h010, 32'hDEADBEEF, 4'b1111, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 2'd2, 12'h010, 32'h0,        4'b0000, 1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 2'd2, 12'h010, 32'h11223344, 4'b1111, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 2'd0, 12'h013, 32'h000000AA, 4'b1000, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 2'd2, 12'h010, 32'h0,        4'b0000, 1'b0, 32'hAA223344};
    vecs[5]  = '{1'b0, 2'd0, 12'h013, 32'h0,        4'b0000, 1'b0, 32'h000000AA};
    vecs[6]  = '{1'b0, 2'd1, 12'h012, 32'h0,        4'b0000, 1'b0, 32'h0000AA22};
    vecs[7]  = '{1'b0, 2'd1, 12'h011, 32'h0,        4'b0000, 1'b1, 32'h0};
    vecs[8]  = '{1'b0, 2'd2, 12'h012, 32'h0,        4'b0000, 1'b1, 32'h0};
    vecs[9]  = '{1'b1, 2'd1, 12'h011, 32'h00005566, 4'b0000, 1'b1, 32'h0};
    vecs[10] = '{1'b0, 2'd3, 12'h010, 32'h0,        4'b0000, 1'b1, 32'h0};
    vecs[11] = '{1'b1, 2'd1, 12'h012, 32'h00005566, 4'b1100, 1'b0, 32'h0};
    vecs[12] = '{1'b0, 2'd2, 12'h010, 32'h0,        4'b0000, 1'b0, 32'h55663344};
    vecs[13] = '{1'b0, 2'd1, 12'h010, 32'h0,        4'b0000, 1'b0, 32'h00003344};
    vecs[14] = '{1'b1, 2'd0, 12'h011, 32'h00000077, 4'b0010, 1'b0, 32'h0};
    vecs[15] = '{1'b0, 2'd2, 12'h010, 32'h0,        4'b0000, 1'b0, 32'h55667744};
    vecs[16] = '{1'b0, 2'd0, 12'h011, 32'h0,        4'b0000, 1'b0, 32'h00000077};

    repeat (2) @(posedge clk);
    resetDut();

    // Directed vectors, one request at a time, response expected 2 cycles later.
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b1, vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata, 1'b1);
      checkOutput($sformatf("vec%0d_accept", i), last_acc, 1);
      checkOutput($sformatf("vec%0d_ram_we", i), last_ram_we, vecs[i].exp_we);
      b = 0;
      last_pop = 1'b0;
      while (!last_pop && b < 8) begin
        applyStimulus(1'b0, 1'b0, 2'd0, 12'h0, 32'h0, 1'b1);
        b++;
      end
      if (!last_pop) checkOutput($sformatf("vec%0d_timeout", i), 0, 1);
      else begin
        checkOutput($sformatf("vec%0d_latency", i), b, 2);
        checkOutput($sformatf("vec%0d_rdata", i), last_rdata, vecs[i].exp_rdata);
        checkOutput($sformatf("vec%0d_err", i), last_err, vecs[i].exp_err);
      end
    end

    // Back-to-back: 16 stores then 16 loads with rsp_ready held high.
    p0 = pops_total;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b1, 2'd2, 12'(32'h100 + 4*i), $urandom, 1'b1);
      checkOutput("b2b_store_accept", last_acc, 1);
    end
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b0, 2'd2, 12'(32'h100 + 4*i), 32'h0, 1'b1);
      checkOutput("b2b_load_accept", last_acc, 1);
    end
    repeat (2) applyStimulus(1'b0, 1'b0, 2'd0, 12'h0, 32'h0, 1'b1);
    checkOutput("b2b_pops", pops_total - p0, 32);

    // Backpressure: only DEPTH accepted, then drain; ready returns after first pop.
    a0 = accepts_total;
    p0 = pops_total;
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 2'd2, 12'(32'h100 + 4*i), 32'h0, 1'b0);
    checkOutput("bp_accepted", accepts_total - a0, DEPTH);
    checkOutput("bp_ready_low", req_ready, 0);
    applyStimulus(1'b0, 1'b0, 2'd0, 12'h0, 32'h0, 1'b1);
    checkOutput("bp_first_pop", last_pop, 1);
    applyStimulus(1'b0, 1'b0, 2'd0, 12'h0, 32'h0, 1'b1);
    checkOutput("bp_ready_after_pop", req_ready, 1);
    repeat (4) applyStimulus(1'b0, 1'b0, 2'd0, 12'h0, 32'h0, 1'b1);
    checkOutput("bp_drained", pops_total - p0, DEPTH);

    // Reset with requests in the FIFO and in flight: nothing stale may appear.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 2'd2, 12'(32'h104 + 4*i), 32'h0, 1'b0);
    resetDut();
    p0 = pops_total;
    repeat (4) applyStimulus(1'b0, 1'b0, 2'd0, 12'h0, 32'h0, 1'b1);
    checkOutput("post_reset_stale", pops_total - p0, 0);
    applyStimulus(1'b1, 1'b0, 2'd2, 12'h010, 32'h0, 1'b1);
    repeat (2) applyStimulus(1'b0, 1'b0, 2'd0, 12'h0, 32'h0, 1'b1);
    checkOutput("post_reset_rsp", last_pop, 1);
    checkOutput("post_reset_rdata", last_rdata, 32'h55667744);

    // Randomized traffic against the model, with one reset in the middle.
    for (int i = 0; i < 400; i++) begin
      logic [1:0]  sz;
      logic [11:0] ad;
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      ad = 12'($urandom_range(0, 63));
      if (sz != 2'd3 && $urandom_range(0, 3) != 0) ad = ad & ~12'((1 << sz) - 1);
      applyStimulus($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), sz, ad, $urandom,
                    $urandom_range(0, 3) != 0);
      if (i == 200) resetDut();
    end
    repeat (10) applyStimulus(1'b0, 1'b0, 2'd0, 12'h0, 32'h0, 1'b1);
    checkOutput("final_queue_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
